// File: rtl/button_event.sv
// ---------------------------------------------------------------------------
// button_event
//
// Turns a clean, synchronized push-button level into discrete key events:
// PRESS, RELEASE, LONG (held past LONG_TICKS hold ticks) and auto-REPEAT
// (every REPEAT_TICKS ticks once LONG has fired). Events leave through a
// one-entry valid/ready buffer; an event that finds the buffer occupied and
// not being drained is dropped and the sticky overflow flag is raised.
//
// Configuration macro: BUTTON_EVENT_REPEAT_EN
//   defined   : LONGHOLD emits REPEAT events every REPEAT_TICKS ticks.
//   undefined : no REPEAT logic; LONGHOLD only waits for the release and
//               code 2'b11 is never produced.
//
// Parameters
//   TICK_DIV     clock cycles per hold tick (>= 2)
//   LONG_TICKS   hold ticks before LONG (>= 1)
//   REPEAT_TICKS hold ticks between REPEATs (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   btn_level  in   debounced button level, 1 = pressed
//   evt_valid  out  event buffer holds an event
//   evt_ready  in   consumer takes the event when evt_valid && evt_ready
//   evt_code   out  00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
//   pressed    out  registered copy of btn_level (previous-cycle level)
//   overflow   out  sticky: an event was dropped (cleared by reset only)
// ---------------------------------------------------------------------------
module button_event #(
    parameter int TICK_DIV     = 100_000,
    parameter int LONG_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_level,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_code,
    output logic       pressed,
    output logic       overflow
);

    // Parameter sanity check at elaboration; the branch is empty for legal values.
    if (TICK_DIV < 2 || LONG_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
        $error("button_event: TICK_DIV must be >= 2, LONG_TICKS and REPEAT_TICKS >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HELD     = 2'd1,
        ST_LONGHOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_RELEASE = 2'b01,
        EVT_LONG    = 2'b10,
        EVT_REPEAT  = 2'b11
    } evt_t;

    localparam int PW = $clog2(TICK_DIV);
`ifdef BUTTON_EVENT_REPEAT_EN
    localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);
    localparam logic [TW-1:0] REPEAT_CNT = TW'(REPEAT_TICKS);
`else
    localparam int TW = $clog2(LONG_TICKS + 1);
`endif
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] LONG_CNT   = TW'(LONG_TICKS);

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [TW-1:0] r_tick;
    logic          r_pressed;
    logic          r_valid;
    evt_t          r_code;
    logic          r_overflow;

    logic          w_rise;
    logic          w_fall;
    logic          w_tick;
    logic [TW-1:0] w_tick_inc;
    logic          w_tick_count_en;
    logic          w_long_hit;
    logic          w_repeat_hit;
    logic          w_gen;
    evt_t          w_gen_code;
    logic          w_can_load;

    assign w_rise     = btn_level & ~r_pressed;
    assign w_fall     = ~btn_level & r_pressed;
    // One hold tick per prescaler wrap; the prescaler only runs while held.
    assign w_tick     = (r_state != ST_IDLE) && (r_presc == PRESC_LAST);
    assign w_tick_inc = r_tick + TW'(1);
    // The event fires on the tick that would bring the counter to the
    // threshold, so LONG lands exactly LONG_TICKS*TICK_DIV cycles after PRESS.
    assign w_long_hit = (r_state == ST_HELD) && w_tick && (w_tick_inc == LONG_CNT);

`ifdef BUTTON_EVENT_REPEAT_EN
    assign w_repeat_hit    = (r_state == ST_LONGHOLD) && w_tick && (w_tick_inc == REPEAT_CNT);
    assign w_tick_count_en = (r_state == ST_HELD) || (r_state == ST_LONGHOLD);
`else
    assign w_repeat_hit    = 1'b0;
    assign w_tick_count_en = (r_state == ST_HELD);
`endif

    // At most one event per cycle; a fall outranks a same-cycle LONG/REPEAT tick.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        w_gen      = 1'b0;
        w_gen_code = EVT_PRESS;
        if (r_state == ST_IDLE) begin
            if (w_rise) begin
                w_gen      = 1'b1;
                w_gen_code = EVT_PRESS;
            end
        end else if (w_fall) begin
            w_gen      = 1'b1;
            w_gen_code = EVT_RELEASE;
        end else if (w_long_hit) begin
            w_gen      = 1'b1;
            w_gen_code = EVT_LONG;
        end else if (w_repeat_hit) begin
            w_gen      = 1'b1;
            w_gen_code = EVT_REPEAT;
        end
    end

    // The buffer can take a new event when empty or when its entry leaves this cycle.
    assign w_can_load = ~r_valid | evt_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_presc    <= '0;
            r_tick     <= '0;
            r_pressed  <= 1'b0;
            r_valid    <= 1'b0;
            r_code     <= EVT_PRESS;
            r_overflow <= 1'b0;
        end else begin
            r_pressed <= btn_level;

            case (r_state)
                ST_IDLE: begin
                    r_presc <= '0;
                    r_tick  <= '0;
                    if (w_rise) begin
                        r_state <= ST_HELD;
                    end
                end
                ST_HELD, ST_LONGHOLD: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                        r_presc <= '0;
                        r_tick  <= '0;
                    end else begin
                        r_presc <= w_tick ? '0 : r_presc + PW'(1);
                        if (w_long_hit) begin
                            r_state <= ST_LONGHOLD;
                            r_tick  <= '0;
                        end else if (w_repeat_hit) begin
                            r_tick <= '0;
                        end else if (w_tick && w_tick_count_en) begin
                            r_tick <= w_tick_inc;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_presc <= '0;
                    r_tick  <= '0;
                end
            endcase

            // One-entry event buffer; code is only rewritten on a load, so a
            // pending event stays stable under back-pressure.
            if (w_gen) begin
                if (w_can_load) begin
                    r_valid <= 1'b1;
                    r_code  <= w_gen_code;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_valid && evt_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign evt_valid = r_valid;
    assign evt_code  = r_code;
    assign pressed   = r_pressed;
    assign overflow  = r_overflow;

endmodule

// File: doc/button_event.md
# button_event

Converts the debounced push-button level from the input debouncer into discrete, timestamp-free key events: PRESS, RELEASE, LONG (held past a threshold) and auto-REPEAT. It sits directly downstream of the debouncer and ahead of the keyboard/memory-mapped input logic. Events are delivered through a one-entry valid/ready buffer, and lost events are flagged.

## Interface
- TICK_DIV, 100_000, clock cycles per hold tick (1 ms at 100 MHz); must be ≥ 2
- LONG_TICKS, 500, ticks of continuous hold before LONG; must be ≥ 1
- REPEAT_TICKS, 100, ticks between REPEAT events; must be ≥ 1
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- btn_level  input  1  clean, already synchronized button level (1 = pressed)
- evt_valid  output  1  event buffer holds an event
- evt_ready  input  1  consumer accepts the event when evt_valid && evt_ready
- evt_code  output  2  00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
- pressed  output  1  registered copy of btn_level
- overflow  output  1  sticky flag: an event was dropped

## Operation
- Edge detection: `pressed` holds the previous-cycle level.
  - Rise: btn_level=1 && pressed=0.
  - Fall: btn_level=0 && pressed=1.
- FSM states: IDLE, HELD, LONGHOLD.
  - IDLE → HELD on rise. Emit PRESS; clear the prescaler and the tick counter.
  - HELD → LONGHOLD when the tick counter reaches LONG_TICKS. Emit LONG; clear the tick counter.
  - LONGHOLD: each time the tick counter reaches REPEAT_TICKS, emit REPEAT and clear the tick counter.
  - HELD or LONGHOLD → IDLE on fall. Emit RELEASE and stop counting.
  - A fall before LONG_TICKS produces PRESS then RELEASE only, with no LONG.
- Prescaler:
  - Counts 0..TICK_DIV-1 while in HELD or LONGHOLD. Its wrap is one tick.
  - Width is $clog2(TICK_DIV).
  - The tick counter width is $clog2(max(LONG_TICKS, REPEAT_TICKS)+1).
  - Both counters are held at 0 in IDLE.
- Event buffer (one entry):
  - A new event loads when the buffer is empty, or when the current entry is being accepted in the same cycle.
  - Otherwise the new event is dropped and `overflow` is set.
  - A held event keeps evt_code stable until it is accepted.
- Simultaneous events: the FSM generates at most one event per cycle. A fall takes priority over a same-cycle LONG/REPEAT tick; RELEASE is emitted and the tick is discarded.
- overflow is cleared only by reset.

## Timing
- Reset values: evt_valid=0, evt_code=00, pressed=0, overflow=0, FSM=IDLE, all counters 0.
- Reset is asynchronous and may occur mid-hold or with an event pending. Any pending event is discarded.
- If btn_level is 1 when reset_n deasserts, a rise is seen on the first clock and PRESS is emitted.
- Latency: a rise first sampled at edge N gives evt_valid=1, evt_code=PRESS after edge N (visible in cycle N+1). Fall-to-RELEASE latency is the same.
- LONG becomes valid exactly LONG_TICKS·TICK_DIV cycles after PRESS becomes valid.
- The first REPEAT becomes valid REPEAT_TICKS·TICK_DIV cycles after LONG. Further REPEATs follow at the same period.
- Counting does not depend on evt_ready; back-pressure never stretches the hold timing.
- Handshake: evt_valid falls in the cycle after acceptance unless a new event loads in that same cycle.

## Configuration
- Macro: BUTTON_EVENT_REPEAT_EN.
- Defined: LONGHOLD emits REPEAT events as described.
- Undefined:
  - The REPEAT logic is absent.
  - LONGHOLD waits for the fall only.
  - Code 11 is never produced.
  - The tick counter width is $clog2(LONG_TICKS+1).

## Test plan
All scenarios use TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2, with evt_ready=1 unless stated.

- **Reset:** hold reset_n=0 with btn_level=1 → all outputs 0. Release reset → PRESS valid 1 cycle later.
- **Short press:** raise btn_level at edge 0 and drop it at edge 6 → PRESS valid in cycle 1 and RELEASE valid in cycle 7; no LONG.
- **Long hold with repeat:** raise btn_level at edge 0 and hold → PRESS in cycle 1, LONG in cycle 13, REPEAT in cycles 21 and 29.
  - Release at edge 30 → RELEASE in cycle 31.
  - With the macro undefined: no REPEAT in cycles 21 or 29.
- **Back-pressure:** evt_ready=0, press at edge 0, release at edge 3 → PRESS held stable, RELEASE dropped, overflow=1 from cycle 4.
  - Then evt_ready=1 → PRESS accepted and evt_valid=0 in the next cycle; overflow stays 1.
- **Accept and load in the same cycle:** evt_ready rises in the same cycle RELEASE is generated → RELEASE loads and overflow stays 0.
- **Fall coinciding with the LONG tick:** fall sampled at edge 12 → RELEASE in cycle 13 and no LONG event.
